robertson_ctrl: RTL and testbench
=================================

Name: robertson_ctrl

Overview:
Control FSM for the Robertson signed (two's-complement) shift-add multiplier datapath. It sequences load, add, subtract-correction and arithmetic-shift strobes over WIDTH multiplier bits. An internal down-counter tracks the remaining bit positions. A start/done/ack handshake connects it to the lab top level.

Parameters:
WIDTH, 8, operand width in bits; number of multiplier bits processed; legal range 2..128.
CW, 4, iteration counter width; must satisfy 2**CW > WIDTH-1 (elaboration-time check, $error on violation).

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a multiply; sampled only in IDLE.
abort  input  1  cancel an in-progress multiply; sampled in LOAD/TEST/ADD/SUB/SHIFT.
ack  input  1  consumer has taken the result; sampled only in DONE.
q_lsb  input  1  current LSB of the datapath multiplier (Q) register.
load_regs  output  1  load X and Q operand registers, clear accumulator A.
add_en  output  1  A <= A + X this cycle.
sub_en  output  1  A <= A - X this cycle (sign-bit correction).
shift_en  output  1  arithmetic right shift of {A,Q} this cycle.
busy  output  1  high in every state except IDLE and DONE.
done  output  1  result valid in datapath; held until ack.
count  output  CW  remaining non-sign bit positions.

Behaviour:
- States: IDLE, LOAD, TEST, ADD, SUB, SHIFT, DONE.
- Outputs are Moore, decoded from the state register only:
  - load_regs=LOAD, add_en=ADD, sub_en=SUB, shift_en=SHIFT, done=DONE.
  - busy = not IDLE and not DONE.
  - At most one strobe is high in any cycle.
- Reset (any state, mid-operation included): next state IDLE, count <= 0. All outputs are 0 in the cycle after the reset edge.
- IDLE: start=1 -> LOAD; otherwise stay in IDLE.
- LOAD: count <= WIDTH-1; -> TEST.
- TEST, count != 0 (non-sign bit): q_lsb=1 -> ADD, else -> SHIFT.
- TEST, count == 0 (sign bit): q_lsb=1 -> SUB, else -> SHIFT.
- ADD -> SHIFT. SUB -> SHIFT.
- SHIFT:
  - count == 0: -> DONE, count holds at 0.
  - count != 0: count <= count-1 (down-counter, no wrap), -> TEST.
- DONE: ack=1 -> IDLE. A start in the same cycle as ack is ignored; a new start must be presented while in IDLE.
- abort=1 in any busy state -> IDLE next cycle, count <= 0, done never asserted.
  - abort beats every other transition.
  - abort is ignored in IDLE and DONE.
  - reset beats abort.
- start while busy or in DONE: ignored, no effect on sequence.
- count changes only in LOAD, SHIFT, abort and reset.
- Latency, with N = number of 1 bits in the WIDTH-bit multiplier and the start-sampling edge as cycle 0:
  - LOAD occupies cycle 1.
  - done first high in cycle 2 + 2*WIDTH + N.
  - Exactly WIDTH shift_en pulses, N-(sign bit) add_en pulses, and 1 sub_en pulse iff the multiplier MSB is 1.
- q_lsb is the only datapath feedback; it is examined only in TEST.

Test Plan:
- Reset: reset=1 in SHIFT mid-multiply -> next cycle state IDLE, count=0, busy=done=load_regs=add_en=sub_en=shift_en=0.
- WIDTH=8, multiplier 0x00, start pulse -> load_regs 1 cycle, 8 shift_en, 0 add_en, 0 sub_en; done high at cycle 18; holds until ack, then IDLE.
- WIDTH=8, multiplier 0xFF (-1), datapath model with X=0x03 -> 7 add_en, 1 sub_en immediately before the last shift_en, done at cycle 26; product 0xFFFD (-3).
- WIDTH=8, X=0x85 (-123), Q=0x46 (70) -> 3 add_en, 0 sub_en, done at cycle 21; product 0xDE5E (-8610). Check count sequence 7,6,...,0 across TEST visits.
- abort=1 asserted on the 3rd TEST visit -> IDLE next cycle, no done pulse. A following start runs a full, correct multiply.
- start held high through an entire multiply, and ack and start asserted together in DONE -> no re-trigger while busy; IDLE after ack; new LOAD only on the next IDLE-cycle start.

Source files
------------

// File: rtl/robertson_ctrl.sv
// robertson_ctrl
//   Control FSM for a Robertson signed (two's-complement) shift-add multiplier.
//   Sequences the load, add, subtract-correction and arithmetic-shift strobes
//   over WIDTH multiplier bits. A down-counter tracks the remaining non-sign
//   bit positions. A start/done/ack handshake connects it to the top level.
//
// Parameters
//   WIDTH     operand width in bits (2..128)
//   CW        iteration counter width, 2**CW > WIDTH-1
//
// Ports
//   clk        system clock, all state updates on posedge
//   reset      synchronous, active-high reset
//   start      request a multiply (sampled in IDLE only)
//   abort      cancel an in-progress multiply (sampled in busy states)
//   ack        consumer has taken the result (sampled in DONE only)
//   q_lsb      current LSB of the datapath Q register (examined in TEST only)
//   load_regs  load X and Q, clear A
//   add_en     A <= A + X
//   sub_en     A <= A - X (sign-bit correction)
//   shift_en   arithmetic right shift of {A,Q}
//   busy       high in every state except IDLE and DONE
//   done       result valid, held until ack
//   count      remaining non-sign bit positions
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | operands loaded, accumulator cleared, counter preset
// TEST   | examine q_lsb; choose ADD (non-sign bit), SUB (sign bit) or SHIFT
// ADD    | A <= A + X
// SUB    | A <= A - X, only for a 1 in the multiplier sign bit
// SHIFT  | arithmetic shift of {A,Q}; last shift leads to DONE
// DONE   | product valid, waiting for ack

module robertson_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          ack,
    input  logic          q_lsb,
    output logic          load_regs,
    output logic          add_en,
    output logic          sub_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
        $error("robertson_ctrl: WIDTH=%0d outside 2..128", WIDTH);
    end
    if ((2 ** CW) <= (WIDTH - 1)) begin : g_bad_cw
        $error("robertson_ctrl: CW=%0d too narrow for WIDTH=%0d", CW, WIDTH);
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SUB   = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_busy;

    // Busy decode is shared by the abort override and the busy output.
    assign in_busy = (state_q != S_IDLE) && (state_q != S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = COUNT_INIT;
                state_d = S_TEST;
            end
            S_TEST: begin
                // count == 0 means the current bit is the multiplier sign bit,
                // whose weight is negative: a 1 there subtracts X.
                if (q_lsb) state_d = (count_q == '0) ? S_SUB : S_ADD;
                else       state_d = S_SHIFT;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q - CW'(1);
                    state_d = S_TEST;
                end
            end
            S_DONE: begin
                // start in the same cycle as ack is not a new request.
                if (ack) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        // abort wins over every busy-state transition.
        if (abort && in_busy) begin
            state_d = S_IDLE;
            count_d = '0;
        end
    end

    // Moore output decode
    always_comb begin
        load_regs = 1'b0;
        add_en    = 1'b0;
        sub_en    = 1'b0;
        shift_en  = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_LOAD:  load_regs = 1'b1;
            S_ADD:   add_en    = 1'b1;
            S_SUB:   sub_en    = 1'b1;
            S_SHIFT: shift_en  = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
        busy = in_busy;
    end

    assign count = count_q;

endmodule

// File: tb/tb_robertson_ctrl.sv
module tb_robertson_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ack = 1'b0;
    logic          q_lsb;
    logic          load_regs, add_en, sub_en, shift_en, busy, done;
    logic [CW-1:0] count;

    int n_vec = 0;
    int n_err = 0;

    robertson_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .q_lsb(q_lsb), .load_regs(load_regs), .add_en(add_en), .sub_en(sub_en),
        .shift_en(shift_en), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    // Datapath model: A carries one guard bit so A+X / A-X never overflows.
    logic [7:0]        x_op = '0, m_op = '0;
    logic signed [8:0] a_m = '0;
    logic [7:0]        q_m = '0, x_m = '0;
    assign q_lsb = q_m[0];

    always @(posedge clk) begin
        if (load_regs) begin
            a_m <= '0;
            q_m <= m_op;
            x_m <= x_op;
        end else if (add_en) begin
            a_m <= a_m + $signed({x_m[7], x_m});
        end else if (sub_en) begin
            a_m <= a_m - $signed({x_m[7], x_m});
        end else if (shift_en) begin
            {a_m, q_m} <= $signed({a_m, q_m}) >>> 1;
        end
    end

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  m;
        logic [15:0] prod;
        int          adds;
        int          subs;
        int          done_cyc;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_strobes"}, {load_regs, add_en, sub_en, shift_en}, 0);
        check({name, "_count"}, count, 0);
    endtask

    // Runs one multiply from a start pulse; returns at the first done cycle,
    // or after an abort on TEST visit abort_at (0 = no abort).
    task automatic run(input vec_t v, input bit hold, input int abort_at);
        int  n_add = 0, n_sub = 0, n_shift = 0, n_load = 0, tvis = 0;
        int  last_sub = -1, last_shift = -1, n_done;
        bit  seen_done = 0;
        vec_t e;
        @(negedge clk);
        x_op  = v.x;
        m_op  = v.m;
        start = 1'b1;
        if (abort_at == 0) sb.push_back(v);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 300 && !seen_done; c++) begin
            @(negedge clk);
            check("strobe_onehot", ($countones({load_regs, add_en, sub_en, shift_en, done}) <= 1), 1);
            if (c == 1) check("load_cycle1", load_regs, 1);
            n_load  += int'(load_regs);
            n_add   += int'(add_en);
            n_sub   += int'(sub_en);
            n_shift += int'(shift_en);
            if (sub_en)   last_sub = c;
            if (shift_en) last_shift = c;
            if (busy && !load_regs && !add_en && !sub_en && !shift_en) begin
                check("test_count", count, WIDTH - 1 - tvis);
                tvis++;
                if (abort_at != 0 && tvis == abort_at) begin
                    abort = 1'b1;
                    @(posedge clk);
                    #1;
                    abort = 1'b0;
                    @(negedge clk);
                    check_idle("abort");
                    n_done = 0;
                    repeat (30) begin
                        @(negedge clk);
                        n_done += int'(done);
                    end
                    check("abort_no_done", n_done, 0);
                    return;
                end
            end
            if (done) begin
                seen_done = 1;
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", c, e.done_cyc);
                    check("add_pulses", n_add, e.adds);
                    check("sub_pulses", n_sub, e.subs);
                    check("shift_pulses", n_shift, WIDTH);
                    check("load_pulses", n_load, 1);
                    check("product", {a_m[7:0], q_m}, e.prod);
                    check("test_visits", tvis, WIDTH);
                    if (e.subs != 0) check("sub_before_last_shift", last_shift - last_sub, 1);
                end
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
    endtask

    task automatic finish_ack();
        repeat (2) begin
            @(negedge clk);
            check("done_held", done, 1);
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        check("after_ack_done", done, 0);
        check("after_ack_busy", busy, 0);
    endtask

    initial begin
        int  guard;
        // x, m, product, adds, subs, done cycle (2 + 2*WIDTH + ones(m))
        vecs[0] = '{8'h03, 8'h00, 16'h0000, 0, 0, 18};
        vecs[1] = '{8'h03, 8'hFF, 16'hFFFD, 7, 1, 26};
        vecs[2] = '{8'h85, 8'h46, 16'hDE5E, 3, 0, 21};
        vecs[3] = '{8'h7F, 8'h80, 16'hC080, 0, 1, 19};
        vecs[4] = '{8'h80, 8'h80, 16'h4000, 0, 1, 19};
        vecs[5] = '{8'hFF, 8'h01, 16'hFFFF, 1, 0, 19};
        vecs[6] = '{8'h5A, 8'hA5, 16'hE002, 3, 1, 22};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset");

        foreach (vecs[i]) begin
            run(vecs[i], 0, 0);
            finish_ack();
        end

        // Abort on the 3rd TEST visit, then a clean multiply.
        run(vecs[2], 0, 3);
        run(vecs[2], 0, 0);
        finish_ack();

        // start held through a whole multiply, then ack together with start.
        run(vecs[1], 1, 0);
        @(negedge clk);
        check("hold_done", done, 1);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        check("ack_start_idle_busy", busy, 0);
        check("ack_start_idle_load", load_regs, 0);
        check("ack_start_idle_done", done, 0);
        @(negedge clk);
        check("idle_start_load", load_regs, 1);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("rerun_done", done, 1);
        check("rerun_product", {a_m[7:0], q_m}, 16'hFFFD);
        finish_ack();

        // Reset while in SHIFT mid-multiply (second shift, count nonzero).
        @(negedge clk);
        x_op  = 8'h03;
        m_op  = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (guard < 2 && guard >= 0) begin
            @(negedge clk);
            if (shift_en) guard++;
            if (done) guard = -1;
        end
        check("mid_shift_reached", guard, 2);
        check("mid_shift_count", count, 6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
